// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, ALU op classes and the decoded control bundle.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_OP_ADD   = 3'b000;
    localparam logic [2:0] ALU_OP_SUB   = 3'b001;
    localparam logic [2:0] ALU_OP_FUNCT = 3'b010;

    localparam int CTRL_W = 9;

    // Bit order, MSB first: reg_dst, mem_read, mem_write, mem_to_reg, alu_src, reg_write, alu_op[2:0]
    typedef struct packed {
        logic       reg_dst;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic [2:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the instruction in ID.
module hazard_detect #(
    parameter int RW = 5
) (
    input  logic          ex_mem_read,
    input  logic [RW-1:0] ex_rt,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    output logic          hz
);

    // Register 0 is hardwired to zero, so writing it never creates a dependency.
    assign hz = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Optional performance counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_Reg_Dst,
    input  logic          id_Mem_Read,
    input  logic          id_Mem_Write,
    input  logic          id_Mem_To_Reg,
    input  logic          id_ALU_Src,
    input  logic          id_Reg_Write,
    input  logic [2:0]    id_ALU_Op,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [5:0]    id_funct,
    input  logic          flush,
    input  logic          stall_in,
    output logic          NoOp,
    output logic          stall_ifid,
    output logic          ex_Reg_Dst,
    output logic          ex_Mem_Read,
    output logic          ex_Mem_Write,
    output logic          ex_Mem_To_Reg,
    output logic          ex_ALU_Src,
    output logic          ex_Reg_Write,
    output logic [2:0]    ex_ALU_Op,
    output logic [DW-1:0] ex_rd1,
    output logic [DW-1:0] ex_rd2,
    output logic [DW-1:0] ex_imm,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] ex_rd,
    output logic [5:0]    ex_funct,
    output logic [CW-1:0] bubble_cnt,
    output logic [CW-1:0] stall_cnt
);

    ctrl_t         id_ctrl;
    ctrl_t         ctrl_d, ctrl_q;
    logic [DW-1:0] rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
    logic [RW-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
    logic [5:0]    funct_d, funct_q;
    logic          hz;

    assign id_ctrl = {id_Reg_Dst, id_Mem_Read, id_Mem_Write, id_Mem_To_Reg,
                      id_ALU_Src, id_Reg_Write, id_ALU_Op};

    hazard_detect #(.RW(RW)) u_hazard_detect (
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rt       (rt_q),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .hz          (hz)
    );

    assign NoOp       = hz;
    assign stall_ifid = hz || stall_in;

    // Flush and bubble both load data but clear controls locally, independent of NoOp.
    always_comb begin
        ctrl_d  = ctrl_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        funct_d = funct_q;
        if (flush || !stall_in) begin
            ctrl_d  = (flush || hz) ? '0 : id_ctrl;
            rd1_d   = id_rd1;
            rd2_d   = id_rd2;
            imm_d   = id_imm;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
            funct_d = id_funct;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            funct_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            funct_q <= funct_d;
        end
    end

    assign {ex_Reg_Dst, ex_Mem_Read, ex_Mem_Write, ex_Mem_To_Reg,
            ex_ALU_Src, ex_Reg_Write, ex_ALU_Op} = ctrl_q;
    assign ex_rd1   = rd1_q;
    assign ex_rd2   = rd2_q;
    assign ex_imm   = imm_q;
    assign ex_rs    = rs_q;
    assign ex_rt    = rt_q;
    assign ex_rd    = rd_q;
    assign ex_funct = funct_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [CW-1:0] bubble_cnt_d, bubble_cnt_q;
    logic [CW-1:0] stall_cnt_d, stall_cnt_q;

    // Counters saturate rather than wrap so a long run never reads as a short one.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (!flush && !stall_in && hz && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
        if (stall_in && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`else
    assign bubble_cnt = '0;
    assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus randomized bench for id_ex_stage; expected EX contents queued at drive time.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef ID_EX_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [8:0] C_LW  = 9'b0_1_0_1_1_1_000;
    localparam logic [8:0] C_ADD = 9'b1_0_0_0_0_1_010;

    typedef struct packed {
        logic [8:0]    ctrl;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [5:0]    funct;
    } snap_t;

    typedef struct {
        snap_t s;
        int    bub;
        int    stl;
    } exp_t;

    logic clk = 1'b0;
    logic rst, flush, stall_in;
    logic [8:0] id_ctrl;
    logic id_Reg_Dst, id_Mem_Read, id_Mem_Write, id_Mem_To_Reg, id_ALU_Src, id_Reg_Write;
    logic [2:0] id_ALU_Op;
    logic [DW-1:0] id_rd1, id_rd2, id_imm;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [5:0] id_funct;
    logic NoOp, stall_ifid;
    logic ex_Reg_Dst, ex_Mem_Read, ex_Mem_Write, ex_Mem_To_Reg, ex_ALU_Src, ex_Reg_Write;
    logic [2:0] ex_ALU_Op;
    logic [DW-1:0] ex_rd1, ex_rd2, ex_imm;
    logic [RW-1:0] ex_rs, ex_rt, ex_rd;
    logic [5:0] ex_funct;
    logic [CW-1:0] bubble_cnt, stall_cnt;
    snap_t dut_snap;

    int n_err = 0;
    int n_chk = 0;
    exp_t exp_q[$];
    snap_t m_ex;
    int m_bub, m_stl;
    bit m_valid;

    always #5 clk = ~clk;

    assign {id_Reg_Dst, id_Mem_Read, id_Mem_Write, id_Mem_To_Reg,
            id_ALU_Src, id_Reg_Write, id_ALU_Op} = id_ctrl;
    assign dut_snap = {ex_Reg_Dst, ex_Mem_Read, ex_Mem_Write, ex_Mem_To_Reg, ex_ALU_Src,
                       ex_Reg_Write, ex_ALU_Op, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct};

    id_ex_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .id_Reg_Dst(id_Reg_Dst), .id_Mem_Read(id_Mem_Read), .id_Mem_Write(id_Mem_Write),
        .id_Mem_To_Reg(id_Mem_To_Reg), .id_ALU_Src(id_ALU_Src), .id_Reg_Write(id_Reg_Write),
        .id_ALU_Op(id_ALU_Op), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
        .flush(flush), .stall_in(stall_in), .NoOp(NoOp), .stall_ifid(stall_ifid),
        .ex_Reg_Dst(ex_Reg_Dst), .ex_Mem_Read(ex_Mem_Read), .ex_Mem_Write(ex_Mem_Write),
        .ex_Mem_To_Reg(ex_Mem_To_Reg), .ex_ALU_Src(ex_ALU_Src), .ex_Reg_Write(ex_Reg_Write),
        .ex_ALU_Op(ex_ALU_Op), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [8:0] c, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                         input logic [RW-1:0] rd, input logic [DW-1:0] imm);
        id_ctrl  = c;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
        id_imm   = imm;
        id_rd1   = 32'hA000_0000 | DW'(rs);
        id_rd2   = 32'hB000_0000 | DW'(rt);
        id_funct = 6'(rd + 6'd32);
    endtask

    // One clock: check combinational outputs, push expected EX state, then compare after the edge.
    task automatic cycle();
        logic mhz;
        exp_t e, got;
        snap_t in_snap;
        #1;
        mhz = m_ex.ctrl[7] && (m_ex.rt != 0) && ((m_ex.rt == id_rs) || (m_ex.rt == id_rt));
        if (m_valid) begin
            chk("noop", 128'(NoOp), 128'(mhz));
            chk("stall_ifid", 128'(stall_ifid), 128'(mhz | stall_in));
        end
        in_snap = {id_ctrl, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct};
        if (!rst) begin
            m_ex = '0;
            m_bub = 0;
            m_stl = 0;
        end else begin
            if (PERF && stall_in && m_stl < CMAX) m_stl++;
            if (flush) begin
                m_ex = in_snap;
                m_ex.ctrl = '0;
            end else if (stall_in) begin
                m_ex = m_ex;
            end else if (mhz) begin
                m_ex = in_snap;
                m_ex.ctrl = '0;
                if (PERF && m_bub < CMAX) m_bub++;
            end else begin
                m_ex = in_snap;
            end
        end
        e.s = m_ex;
        e.bub = m_bub;
        e.stl = m_stl;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk("ex_state", 128'(dut_snap), 128'(got.s));
        chk("bubble_cnt", 128'(bubble_cnt), 128'(got.bub));
        chk("stall_cnt", 128'(stall_cnt), 128'(got.stl));
        m_valid = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        m_ex = '0;
        m_bub = 0;
        m_stl = 0;
        m_valid = 1'b0;
        rst = 1'b0;
        flush = 1'b0;
        stall_in = 1'b0;
        drive(C_LW, 5'd2, 5'd3, 5'd0, 32'h10);

        // Reset with nonzero inputs
        cycle();
        cycle();
        chk("rst_noop", 128'(NoOp), 128'(0));
        chk("rst_mem_read", 128'(ex_Mem_Read), 128'(0));
        chk("rst_bubble_cnt", 128'(bubble_cnt), 128'(0));

        // Pass-through of a load
        rst = 1'b1;
        cycle();
        chk("pt_mem_read", 128'(ex_Mem_Read), 128'(1));
        chk("pt_rt", 128'(ex_rt), 128'(3));
        chk("pt_imm", 128'(ex_imm), 128'(32'h10));

        // Load-use: add rs=3 behind lw rt=3
        drive(C_ADD, 5'd3, 5'd4, 5'd5, 32'h0);
        #1;
        chk("lu_noop_hi", 128'(NoOp), 128'(1));
        chk("lu_stall_hi", 128'(stall_ifid), 128'(1));
        cycle();
        chk("lu_bubble_regwrite", 128'(ex_Reg_Write), 128'(0));
        chk("lu_bubble_cnt", 128'(bubble_cnt), 128'(PERF ? 1 : 0));
        #1;
        chk("lu_noop_lo", 128'(NoOp), 128'(0));
        cycle();
        chk("lu_add_regwrite", 128'(ex_Reg_Write), 128'(1));
        chk("lu_add_rs", 128'(ex_rs), 128'(3));

        // Register 0 is never a hazard
        drive(C_LW, 5'd1, 5'd0, 5'd0, 32'h4);
        cycle();
        drive(C_ADD, 5'd0, 5'd0, 5'd6, 32'h0);
        #1;
        chk("r0_noop", 128'(NoOp), 128'(0));
        cycle();
        chk("r0_regwrite", 128'(ex_Reg_Write), 128'(1));

        // Flush coinciding with a hazard
        drive(C_LW, 5'd1, 5'd7, 5'd0, 32'h8);
        cycle();
        drive(C_ADD, 5'd7, 5'd2, 5'd8, 32'h0);
        flush = 1'b1;
        #1;
        chk("fl_stall_ifid", 128'(stall_ifid), 128'(1));
        cycle();
        flush = 1'b0;
        chk("fl_ctrl", 128'(dut_snap.ctrl), 128'(0));
        chk("fl_bubble_cnt", 128'(bubble_cnt), 128'(PERF ? 1 : 0));

        // Stall hold for three cycles with changing inputs
        drive(C_LW, 5'd1, 5'd9, 5'd0, 32'h20);
        cycle();
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(C_ADD, 5'(10 + i), 5'(11 + i), 5'(12 + i), 32'(i + 100));
            cycle();
        end
        chk("st_rt_held", 128'(ex_rt), 128'(9));
        chk("st_imm_held", 128'(ex_imm), 128'(32'h20));
        chk("st_stall_cnt", 128'(stall_cnt), 128'(PERF ? 3 : 0));

        // Flush beats stall
        flush = 1'b1;
        drive(C_LW, 5'd4, 5'd5, 5'd0, 32'h30);
        cycle();
        chk("fs_ctrl", 128'(dut_snap.ctrl), 128'(0));
        chk("fs_imm", 128'(ex_imm), 128'(32'h30));
        flush = 1'b0;
        stall_in = 1'b0;

        // Random traffic with small register range to provoke hazards and saturation
        for (int i = 0; i < 60; i++) begin
            drive(9'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 31)), $urandom);
            flush = ($urandom_range(0, 7) == 0);
            stall_in = ($urandom_range(0, 2) == 0);
            cycle();
        end
        flush = 1'b0;
        stall_in = 1'b0;

        // Reset with a hazard pending
        drive(C_LW, 5'd1, 5'd6, 5'd0, 32'h0);
        cycle();
        drive(C_ADD, 5'd6, 5'd6, 5'd1, 32'h0);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        #1;
        chk("mr_noop", 128'(NoOp), 128'(0));
        chk("mr_state", 128'(dut_snap), 128'(0));
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
